// File: rtl/trap_int_pkg.sv
// Shared types and widths for the trapezoid integrator controller and its surface calculator.
package trap_int_pkg;

    localparam int SAMPLE_W = 16;
    localparam int SURF_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/trapezoid_surf_calc.sv
// Registered trapezoid partial surface: surf = (a + b) << 3, captured when en is high.
module trapezoid_surf_calc
    import trap_int_pkg::*;
(
    input  logic                clk,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    output logic [SURF_W-1:0]   surf,
    output logic                valid
);

    // NOTE: these registers are deliberately unreset; the consumer qualifies surf
    // with its own reset flop, so power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (en) begin
            surf  <= SURF_W'((SURF_W'(a) + SURF_W'(b)) << 3);
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/trapezoid_integrator_ctrl.sv
// Pairs consecutive samples into the surface calculator and accumulates the
// returned partial surfaces over a programmed sample count, saturating on overflow.
module trapezoid_integrator_ctrl
    import trap_int_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_samples,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                s_ready,
    output logic [ACC_W-1:0]    result,
    output logic                result_valid,
    output logic                busy,
    output logic                overflow,
    output logic                err_cfg
);

    localparam int SUM_W = ((ACC_W > SURF_W) ? ACC_W : SURF_W) + 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_inc;
    logic [SAMPLE_W-1:0] prev_q;
    logic [ACC_W-1:0]    acc_q;
    logic                issue_d;
    logic                calc_en;
    logic [SURF_W-1:0]   surf;
    logic                calc_valid_unused;
    logic [SUM_W-1:0]    sum;
    logic                sum_ovf;
    logic                accept;

    trapezoid_surf_calc u_calc (
        .clk   (clk),
        .en    (calc_en),
        .a     (prev_q),
        .b     (s_data),
        .surf  (surf),
        .valid (calc_valid_unused)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign accept  = s_valid && s_ready;
    // Wide enough that a carry out of the accumulator is always visible.
    assign sum     = SUM_W'(acc_q) + SUM_W'(surf);
    assign sum_ovf = |sum[SUM_W-1:ACC_W];

    // NOTE: all nets written here get a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        calc_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_samples < CNT_W'(2)) ? DONE : PRIME;
                end
            end
            PRIME: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    calc_en = 1'b1;
                    if (cnt_inc == n_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q          <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            acc_q        <= '0;
            issue_d      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            err_cfg      <= 1'b0;
        end else begin
            issue_d <= calc_en;

            // surf is only trustworthy the cycle after an issue.
            if (issue_d) begin
                if (sum_ovf) begin
                    acc_q    <= '1;
                    overflow <= 1'b1;
                end else begin
                    acc_q <= sum[ACC_W-1:0];
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q          <= num_samples;
                        result_valid <= 1'b0;
                        overflow     <= 1'b0;
                        acc_q        <= '0;
                        cnt_q        <= '0;
                        err_cfg      <= (num_samples < CNT_W'(2));
                        busy         <= (num_samples >= CNT_W'(2));
                    end
                end
                PRIME: begin
                    if (accept) begin
                        prev_q <= s_data;
                        cnt_q  <= CNT_W'(1);
                    end
                end
                RUN: begin
                    if (accept) begin
                        prev_q <= s_data;
                        cnt_q  <= cnt_inc;
                    end
                end
                DONE: begin
                    result       <= acc_q;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
